// File: rtl/getir_istek_zamanlayici.sv
// Instruction-fetch request sequencer between getir1, the L1B cache and getir2.
// Tracks outstanding request PS values in a FIFO, tags responses in order, and drops stale responses after a flush.
module getir_istek_zamanlayici #(
  parameter int PS_BIT       = 32,
  parameter int VERI_BIT     = 32,
  parameter int MAX_BEKLEYEN = 4,
  parameter int SAYAC_BIT    = 3
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [PS_BIT-1:0]    g1_ps_i,
  input  logic                 g1_ps_gecerli_i,
  output logic                 g1_ps_hazir_o,
  output logic [PS_BIT-1:0]    l1b_istek_ps_o,
  output logic                 l1b_istek_gecerli_o,
  input  logic                 l1b_istek_hazir_i,
  input  logic [VERI_BIT-1:0]  l1b_buyruk_i,
  input  logic                 l1b_buyruk_gecerli_i,
  output logic                 l1b_buyruk_hazir_o,
  output logic [VERI_BIT-1:0]  g2_buyruk_o,
  output logic [PS_BIT-1:0]    g2_ps_o,
  output logic                 g2_gecerli_o,
  input  logic                 g2_hazir_i,
  input  logic                 bosalt_i,
  output logic [SAYAC_BIT-1:0] bekleyen_sayisi_o
);

  // state  | meaning
  // CALIS  | normal operation: issue requests, forward responses
  // BOSALT | flush drain: drop responses of requests issued before the flush

  localparam int PTR_BIT = (MAX_BEKLEYEN > 1) ? $clog2(MAX_BEKLEYEN) : 1;
  localparam logic [SAYAC_BIT-1:0] MAX_CNT = SAYAC_BIT'(MAX_BEKLEYEN);

  typedef enum logic {CALIS, BOSALT} durum_t;

  durum_t state, state_ns;

  logic [PS_BIT-1:0]    ps_fifo [MAX_BEKLEYEN];
  logic [PTR_BIT-1:0]   wr_ptr, rd_ptr;
  logic [SAYAC_BIT-1:0] count, drop, drop_ns;
  logic                 izin, istek_hs, cevap_hs;

  // All handshake outputs are held low while reset is asserted.
  assign izin = !rst_i && (state == CALIS) && !bosalt_i && (count < MAX_CNT);
  assign l1b_istek_gecerli_o = g1_ps_gecerli_i && izin;
  assign g1_ps_hazir_o = l1b_istek_gecerli_o && l1b_istek_hazir_i;
  assign istek_hs = g1_ps_hazir_o;
  assign l1b_istek_ps_o = g1_ps_i;

  assign l1b_buyruk_hazir_o = !rst_i &&
                              ((state == BOSALT) || bosalt_i || !g2_gecerli_o || g2_hazir_i);
  assign cevap_hs = l1b_buyruk_gecerli_i && l1b_buyruk_hazir_o;
  assign drop_ns = count - SAYAC_BIT'(cevap_hs);

  assign bekleyen_sayisi_o = count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state <= CALIS;
    else       state <= state_ns;
  end

  always_comb begin
    state_ns = state;
    case (state)
      CALIS:  if (bosalt_i && drop_ns != '0) state_ns = BOSALT;
      BOSALT: if (cevap_hs && drop == SAYAC_BIT'(1)) state_ns = CALIS;
      default: state_ns = CALIS;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (istek_hs) ps_fifo[wr_ptr] <= g1_ps_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop         <= '0;
      g2_gecerli_o <= 1'b0;
      g2_buyruk_o  <= '0;
      g2_ps_o      <= '0;
    end else if (state == BOSALT) begin
      g2_gecerli_o <= 1'b0;
      if (cevap_hs) drop <= drop - SAYAC_BIT'(1);
    end else if (bosalt_i) begin
      // A response arriving with the flush is already counted out of drop_ns.
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      drop         <= drop_ns;
      g2_gecerli_o <= 1'b0;
    end else begin
      if (istek_hs) wr_ptr <= wr_ptr + PTR_BIT'(1);
      if (cevap_hs) begin
        rd_ptr       <= rd_ptr + PTR_BIT'(1);
        g2_buyruk_o  <= l1b_buyruk_i;
        g2_ps_o      <= ps_fifo[rd_ptr];
        g2_gecerli_o <= 1'b1;
      end else if (g2_hazir_i) begin
        g2_gecerli_o <= 1'b0;
      end
      count <= count + SAYAC_BIT'(istek_hs) - SAYAC_BIT'(cevap_hs);
    end
  end

  bos_fifo_cevap : assert property (@(posedge clk_i) disable iff (rst_i)
    !(cevap_hs && state == CALIS && !bosalt_i && count == '0));

endmodule

// File: tb/tb_getir_istek_zamanlayici.sv
// Directed cycle-table bench for getir_istek_zamanlayici; each row is one clock of inputs and expected outputs.
module tb_getir_istek_zamanlayici;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] g1_ps;
  logic        g1_ps_gecerli, g1_ps_hazir;
  logic [31:0] l1b_istek_ps;
  logic        l1b_istek_gecerli, l1b_istek_hazir;
  logic [31:0] l1b_buyruk;
  logic        l1b_buyruk_gecerli, l1b_buyruk_hazir;
  logic [31:0] g2_buyruk, g2_ps;
  logic        g2_gecerli, g2_hazir, bosalt;
  logic [2:0]  bekleyen_sayisi;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  getir_istek_zamanlayici dut (
    .clk_i(clk), .rst_i(rst),
    .g1_ps_i(g1_ps), .g1_ps_gecerli_i(g1_ps_gecerli), .g1_ps_hazir_o(g1_ps_hazir),
    .l1b_istek_ps_o(l1b_istek_ps), .l1b_istek_gecerli_o(l1b_istek_gecerli),
    .l1b_istek_hazir_i(l1b_istek_hazir),
    .l1b_buyruk_i(l1b_buyruk), .l1b_buyruk_gecerli_i(l1b_buyruk_gecerli),
    .l1b_buyruk_hazir_o(l1b_buyruk_hazir),
    .g2_buyruk_o(g2_buyruk), .g2_ps_o(g2_ps), .g2_gecerli_o(g2_gecerli),
    .g2_hazir_i(g2_hazir), .bosalt_i(bosalt), .bekleyen_sayisi_o(bekleyen_sayisi)
  );

  typedef struct {
    logic [31:0] ps;  logic pv; logic ih;
    logic [31:0] d;   logic dv; logic gh; logic fl;
    logic iv; logic ph; logic bh; logic gv;
    logic [31:0] gps; logic [31:0] gd; logic [2:0] cnt;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic [31:0] ps, input logic pv, input logic ih,
                     input logic [31:0] d, input logic dv, input logic gh, input logic fl,
                     input logic iv, input logic ph, input logic bh, input logic gv,
                     input logic [31:0] gps, input logic [31:0] gd, input logic [2:0] cnt);
    vec_t v;
    v.ps = ps; v.pv = pv; v.ih = ih; v.d = d; v.dv = dv; v.gh = gh; v.fl = fl;
    v.iv = iv; v.ph = ph; v.bh = bh; v.gv = gv; v.gps = gps; v.gd = gd; v.cnt = cnt;
    vecs.push_back(v);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic iv, input logic ph, input logic bh,
                         input logic gv, input logic [31:0] gps, input logic [31:0] gd,
                         input logic [2:0] cnt);
    chk({tag, " istek_gecerli"}, 32'(l1b_istek_gecerli), 32'(iv));
    chk({tag, " ps_hazir"},      32'(g1_ps_hazir),       32'(ph));
    chk({tag, " buyruk_hazir"},  32'(l1b_buyruk_hazir),  32'(bh));
    chk({tag, " g2_gecerli"},    32'(g2_gecerli),        32'(gv));
    chk({tag, " g2_ps"},         g2_ps,                  gps);
    chk({tag, " g2_buyruk"},     g2_buyruk,              gd);
    chk({tag, " bekleyen"},      32'(bekleyen_sayisi),   32'(cnt));
  endtask

  initial begin
    //   ps       pv ih d     dv gh fl   iv ph bh gv gps      gd    cnt
    // single fetch, first with L1B not ready
    add(32'h1000, 1, 0, 0,    0, 1, 0,   1, 0, 1, 0, 0,       0,    0);
    add(32'h1000, 1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 0,       0,    0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 0,       0,    1);
    add(0,        0, 1, 'h13, 1, 1, 0,   0, 0, 1, 0, 0,       0,    1);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 1, 32'h1000,'h13, 0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h1000,'h13, 0);
    // back-pressure: four accepted, fifth blocked, responses in order
    add(32'h0,    1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h1000,'h13, 0);
    add(32'h4,    1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h1000,'h13, 1);
    add(32'h8,    1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h1000,'h13, 2);
    add(32'hC,    1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h1000,'h13, 3);
    add(32'h10,   1, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h1000,'h13, 4);
    add(0,        0, 1, 'hA0, 1, 1, 0,   0, 0, 1, 0, 32'h1000,'h13, 4);
    add(0,        0, 1, 'hA1, 1, 1, 0,   0, 0, 1, 1, 32'h0,   'hA0, 3);
    add(0,        0, 1, 'hA2, 1, 1, 0,   0, 0, 1, 1, 32'h4,   'hA1, 2);
    add(0,        0, 1, 'hA3, 1, 1, 0,   0, 0, 1, 1, 32'h8,   'hA2, 1);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 1, 32'hC,   'hA3, 0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'hC,   'hA3, 0);
    // getir2 stall
    add(32'h20,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'hC,   'hA3, 0);
    add(32'h24,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'hC,   'hA3, 1);
    add(0,        0, 1, 'hB0, 1, 0, 0,   0, 0, 1, 0, 32'hC,   'hA3, 2);
    add(0,        0, 1, 'hB1, 1, 0, 0,   0, 0, 0, 1, 32'h20,  'hB0, 1);
    add(0,        0, 1, 'hB1, 1, 0, 0,   0, 0, 0, 1, 32'h20,  'hB0, 1);
    add(0,        0, 1, 'hB1, 1, 1, 0,   0, 0, 1, 1, 32'h20,  'hB0, 1);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 1, 32'h24,  'hB1, 0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 0);
    // flush with three outstanding, three responses dropped
    add(32'h30,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h24,  'hB1, 0);
    add(32'h34,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h24,  'hB1, 1);
    add(32'h38,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h24,  'hB1, 2);
    add(32'h3C,   1, 1, 0,    0, 1, 1,   0, 0, 1, 0, 32'h24,  'hB1, 3);
    add(32'h3C,   1, 1, 'hC0, 1, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 0);
    add(32'h3C,   1, 1, 'hC1, 1, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 0);
    add(32'h3C,   1, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 0);
    add(32'h3C,   1, 1, 'hC2, 1, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 0);
    add(32'h2000, 1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h24,  'hB1, 0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 1);
    add(0,        0, 1, 'hD0, 1, 1, 0,   0, 0, 1, 0, 32'h24,  'hB1, 1);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 1, 32'h2000,'hD0, 0);
    add(0,        0, 1, 0,    0, 1, 0,   0, 0, 1, 0, 32'h2000,'hD0, 0);
    // flush coinciding with the only outstanding response
    add(32'h40,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h2000,'hD0, 0);
    add(0,        0, 1, 'hE0, 1, 1, 1,   0, 0, 1, 0, 32'h2000,'hD0, 1);
    add(32'h44,   1, 1, 0,    0, 1, 0,   1, 1, 1, 0, 32'h2000,'hD0, 0);

    rst = 1'b1; g1_ps = 32'h1000; g1_ps_gecerli = 1'b1; l1b_istek_hazir = 1'b1;
    l1b_buyruk = 32'h55; l1b_buyruk_gecerli = 1'b1; g2_hazir = 1'b1; bosalt = 1'b0;
    #3;
    chk_all("reset", 0, 0, 0, 0, 0, 0, 0);
    #4;
    rst = 1'b0; g1_ps_gecerli = 1'b0; l1b_buyruk_gecerli = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      g1_ps = vecs[i].ps; g1_ps_gecerli = vecs[i].pv; l1b_istek_hazir = vecs[i].ih;
      l1b_buyruk = vecs[i].d; l1b_buyruk_gecerli = vecs[i].dv;
      g2_hazir = vecs[i].gh; bosalt = vecs[i].fl;
      #2;
      chk_all($sformatf("row%0d", i), vecs[i].iv, vecs[i].ph, vecs[i].bh, vecs[i].gv,
              vecs[i].gps, vecs[i].gd, vecs[i].cnt);
    end

    // reset in the middle of a drain with two responses still to drop
    @(negedge clk);
    g1_ps = 32'h48; g1_ps_gecerli = 1'b1; l1b_buyruk_gecerli = 1'b0; bosalt = 1'b0;
    #2;
    chk_all("rst6 push", 1, 1, 1, 0, 32'h2000, 'hD0, 1);
    @(negedge clk);
    bosalt = 1'b1;
    #2;
    chk_all("rst6 flush", 0, 0, 1, 0, 32'h2000, 'hD0, 2);
    @(negedge clk);
    bosalt = 1'b0;
    #2;
    chk_all("rst6 drain", 0, 0, 1, 0, 32'h2000, 'hD0, 0);
    chk("rst6 drop before", 32'(dut.drop), 2);
    #1;
    rst = 1'b1; l1b_buyruk_gecerli = 1'b1;
    #1;
    chk_all("rst6 in reset", 0, 0, 0, 0, 0, 0, 0);
    chk("rst6 state", 32'(dut.state), 0);
    chk("rst6 drop", 32'(dut.drop), 0);
    @(negedge clk);
    rst = 1'b0; l1b_buyruk_gecerli = 1'b0;
    #2;
    chk_all("rst6 after", 1, 1, 1, 0, 0, 0, 0);
    @(negedge clk);
    g1_ps_gecerli = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
